// File: rtl/float_to_fixed_if.sv
// float_to_fixed_if: start/operand/result handshake between a requester and the converter.
interface float_to_fixed_if;
    logic        enable;
    logic [31:0] data;
    logic [21:0] result;
    logic        done;
    logic        busy;
    logic        overflow;
    modport master (output enable, data, input result, done, busy, overflow);
    modport slave (input enable, data, output result, done, busy, overflow);
endinterface

// File: rtl/float_to_fixed.sv
// float_to_fixed: IEEE-754 single to sign-magnitude Q1.20 by iterative right shifts.
// Zero/denormal inputs clear the result; exponents >= 128 saturate and flag overflow.
module float_to_fixed (
    input logic clk,
    input logic rst_n,
    float_to_fixed_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, next;
    logic [23:0] w;
    logic [4:0] cnt, n;
    logic [7:0] exp, diff;
    logic sign, zero, sat, special;
    logic [21:0] result;
    logic done, overflow;
    always_comb begin
        exp = bus.data[30:23];
        diff = 8'd127 - exp;
        n = exp >= 8'd127 ? 5'd0 : (diff > 8'd21 ? 5'd21 : diff[4:0]);
        special = exp == 8'd0 || exp[7];
        next = IDLE;
        case (state)
            IDLE: next = bus.enable ? ((n != 5'd0 && !special) ? SHIFT : DONE) : IDLE;
            SHIFT: next = cnt == 5'd1 ? DONE : SHIFT;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w <= '0;
            cnt <= '0;
            sign <= 1'b0;
            zero <= 1'b0;
            sat <= 1'b0;
            result <= '0;
            done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= state == DONE;
            if (state == IDLE && bus.enable) begin
                w <= {1'b1, bus.data[22:0]};
                cnt <= n;
                sign <= bus.data[31];
                zero <= exp == 8'd0;
                sat <= exp[7];
            end else if (state == SHIFT) begin
                w <= w >> 1;
                cnt <= cnt - 5'd1;
            end
            // Truncation: w[2:0] are the bits below 2^-20 and are dropped.
            if (state == DONE) begin
                result <= zero ? 22'h000000 : {sign, sat ? 21'h1FFFFF : w[23:3]};
                overflow <= sat;
            end
        end
    end
    assign bus.result = result;
    assign bus.done = done;
    assign bus.overflow = overflow;
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_float_to_fixed.sv
// tb_float_to_fixed: directed vectors with hand-computed fixed-point results and latencies.
module tb_float_to_fixed;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    float_to_fixed_if bus ();
    float_to_fixed dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a conversion, scrambles data after acceptance, optionally pokes enable mid-flight.
    task automatic run(input string tag, input logic [31:0] d, input logic [21:0] er,
                       input logic eo, input int el, input int poke);
        int lat;
        @(negedge clk);
        bus.data = d;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        bus.enable = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (poke != 0 && lat == poke) begin
                bus.enable = 1'b1;
                bus.data = 32'h3F800000;
            end else begin
                bus.enable = 1'b0;
                bus.data = 32'hDEADBEEF;
            end
        end while (!bus.done && lat < 40);
        check({tag, " latency"}, lat, el);
        check({tag, " result"}, {10'd0, bus.result}, {10'd0, er});
        check({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, eo});
        @(posedge clk); #1;
        check({tag, " done width"}, {31'd0, bus.done}, 32'd0);
        check({tag, " held"}, {10'd0, bus.result}, {10'd0, er});
    endtask

    initial begin
        bit saw;
        bus.enable = 1'b0;
        bus.data = 32'h0;
        #1;
        check("reset result", {10'd0, bus.result}, 32'd0);
        check("reset flags", {29'd0, bus.busy, bus.done, bus.overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run("one", 32'h3F800000, 22'h100000, 1'b0, 1, 0);
        run("0p75", 32'h3F400000, 22'h0C0000, 1'b0, 2, 0);
        run("m0p5", 32'hBF000000, 22'h280000, 1'b0, 2, 0);
        run("third", 32'h3EAAAAAB, 22'h055555, 1'b0, 3, 0);
        run("max127", 32'h3FFFFFFF, 22'h1FFFFF, 1'b0, 1, 0);
        run("lsb", 32'h35800000, 22'h000001, 1'b0, 21, 0);
        run("tiny", 32'h35000000, 22'h000000, 1'b0, 22, 0);
        run("mtiny", 32'hB5000000, 22'h200000, 1'b0, 22, 0);
        run("three", 32'h40400000, 22'h1FFFFF, 1'b1, 1, 0);
        run("minf", 32'hFF800000, 22'h3FFFFF, 1'b1, 1, 0);
        run("mzero", 32'h80000000, 22'h000000, 1'b0, 1, 0);
        run("denorm", 32'h80000001, 22'h000000, 1'b0, 1, 0);
        run("busy poke", 32'h35800000, 22'h000001, 1'b0, 21, 4);

        // Back-to-back: enable raised in the done cycle is accepted.
        @(negedge clk);
        bus.data = 32'h3F400000;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        bus.enable = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("chain first done", {31'd0, bus.done}, 32'd1);
        check("chain first result", {10'd0, bus.result}, 32'h0C0000);
        bus.data = 32'h3F800000;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        bus.enable = 1'b0;
        check("chain accepted", {30'd0, bus.busy, bus.done}, 32'd2);
        @(posedge clk); #1;
        check("chain second done", {31'd0, bus.done}, 32'd1);
        check("chain second result", {10'd0, bus.result}, 32'h100000);

        // Reset mid-shift aborts without a done pulse.
        @(negedge clk);
        bus.data = 32'h35800000;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        bus.enable = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset result", {10'd0, bus.result}, 32'd0);
        check("async reset flags", {29'd0, bus.busy, bus.done, bus.overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) saw = 1'b1;
        end
        check("no done after abort", {31'd0, saw}, 32'd0);
        run("post reset", 32'h3F800000, 22'h100000, 1'b0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
